tt_sweep_checker: RTL

Exhaustive truth-table sweeper and checker for the 7-input majority-network functions in the classification library. It drives all 128 input minterms into a function-under-test, captures the single-bit response into a 128-bit truth table, and compares that table against an expected hex value. It sits on both sides of one function module: it feeds x0..x6 and consumes out.

---
 rtl/tt_sweep_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tt_sweep_checker.sv
// Exhaustive 7-input truth-table sweeper/checker: drives minterms 0..127, captures f_in into tt, compares with expected.
// Latency: 129+LATENCY cycles from accepted start back to IDLE; done pulses in the cycle after the last capture.
// Backpressure: none; start is ignored unless IDLE, and the function-under-test must answer at fixed LATENCY.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a sweep (IDLE only)
//   expected[127:0]       expected truth table, registered at start
//   x0..x6                minterm stimulus, m = {x6..x0}
//   f_in                  response of the function-under-test
//   busy, done            sweep in progress / one-cycle completion pulse
//   tt[127:0]             captured truth table
//   match, mismatch_cnt, first_fail   compare results
//
// Build option: define TT_CHECK_EN to build the compare logic; without it
// expected is unused and match/mismatch_cnt/first_fail read 0.
module tt_sweep_checker #(
  parameter int LATENCY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] expected,
  output logic         x0,
  output logic         x1,
  output logic         x2,
  output logic         x3,
  output logic         x4,
  output logic         x5,
  output logic         x6,
  input  logic         f_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic         match,
  output logic [7:0]   mismatch_cnt,
  output logic [6:0]   first_fail
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t       state_q, state_d;
  logic [6:0]   idx_q;
  logic [6:0]   x_vec;
  logic         cap_vld;
  logic [6:0]   cap_idx;
  logic [127:0] tt_q;
  logic         accept;

  assign accept = (state_q == IDLE) && start;

  // Capture point: the {valid, index} of each driven minterm, delayed to line
  // up with the response coming back through the function's register stages.
  generate
    if (LATENCY == 0) begin : g_nopipe
      assign cap_vld = (state_q == DRIVE);
      assign cap_idx = idx_q;
    end else begin : g_pipe
      logic [LATENCY-1:0] vld_q;
      logic [6:0]         idx_pipe_q [LATENCY];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY; i++) idx_pipe_q[i] <= '0;
        end else begin
          vld_q[0]      <= (state_q == DRIVE);
          idx_pipe_q[0] <= idx_q;
          for (int i = 1; i < LATENCY; i++) begin
            vld_q[i]      <= vld_q[i-1];
            idx_pipe_q[i] <= idx_pipe_q[i-1];
          end
        end
      end
      assign cap_vld = vld_q[LATENCY-1];
      assign cap_idx = idx_pipe_q[LATENCY-1];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (idx_q == 7'd127) state_d = (LATENCY > 0) ? DRAIN : DONE;
      // Leave only once the last minterm's response has been captured.
      DRAIN:   if (cap_vld && (cap_idx == 7'd127)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= '0;
        tt_q  <= '0;
      end else begin
        // Counter saturates at 127 so x holds the last minterm through DRAIN.
        if ((state_q == DRIVE) && (idx_q != 7'd127)) idx_q <= idx_q + 7'd1;
        if (cap_vld) tt_q[cap_idx] <= f_in;
      end
    end
  end

  assign busy  = (state_q == DRIVE) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign x_vec = busy ? idx_q : 7'd0;
  assign {x6, x5, x4, x3, x2, x1, x0} = x_vec;
  assign tt    = tt_q;

`ifdef TT_CHECK_EN
  logic [127:0] exp_q;
  logic [7:0]   cnt_q;
  logic [6:0]   ff_q;
  logic         found_q;
  logic         match_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q   <= '0;
      cnt_q   <= '0;
      ff_q    <= '0;
      found_q <= 1'b0;
      match_q <= 1'b0;
    end else if (accept) begin
      exp_q   <= expected;
      cnt_q   <= '0;
      ff_q    <= '0;
      found_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      if (cap_vld && (f_in != exp_q[cap_idx])) begin
        cnt_q <= cnt_q + 8'd1;
        if (!found_q) begin
          ff_q    <= cap_idx;
          found_q <= 1'b1;
        end
      end
      if (state_q == DONE) match_q <= (cnt_q == 8'd0);
    end
  end

  // The last capture lands on the edge entering DONE, so match is formed
  // directly from the final count during DONE and held from the register after.
  assign match        = (state_q == DONE) ? (cnt_q == 8'd0) : match_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail   = ff_q;
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign match        = 1'b0;
  assign mismatch_cnt = 8'd0;
  assign first_fail   = 7'd0;
`endif

endmodule
